// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, FSM states,
// one-hot ALU operation bit positions and opcode classification helpers.
package alu_seq_pkg;

    localparam int unsigned OPC_W     = 5;
    localparam int unsigned ALU_OP_W  = 13;
    localparam int unsigned MAX_REG_W = 4;

    localparam logic [OPC_W-1:0] OPC_AND  = 5'b01010;
    localparam logic [OPC_W-1:0] OPC_OR   = 5'b01011;
    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_SHR  = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_SHRA = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_SHL  = 5'b00111;
    localparam logic [OPC_W-1:0] OPC_ROR  = 5'b01000;
    localparam logic [OPC_W-1:0] OPC_ROL  = 5'b01001;
    localparam logic [OPC_W-1:0] OPC_MUL  = 5'b01111;
    localparam logic [OPC_W-1:0] OPC_DIV  = 5'b10000;
    localparam logic [OPC_W-1:0] OPC_NEG  = 5'b10001;
    localparam logic [OPC_W-1:0] OPC_NOT  = 5'b10010;

    // alu_op bit positions, MSB-first order {AND,OR,ADD,SUB,MUL,DIV,SHR,SHRA,SHL,ROR,ROL,NEG,NOT}
    localparam int unsigned ALU_AND  = 12;
    localparam int unsigned ALU_OR   = 11;
    localparam int unsigned ALU_ADD  = 10;
    localparam int unsigned ALU_SUB  = 9;
    localparam int unsigned ALU_MUL  = 8;
    localparam int unsigned ALU_DIV  = 7;
    localparam int unsigned ALU_SHR  = 6;
    localparam int unsigned ALU_SHRA = 5;
    localparam int unsigned ALU_SHL  = 4;
    localparam int unsigned ALU_ROR  = 3;
    localparam int unsigned ALU_ROL  = 2;
    localparam int unsigned ALU_NEG  = 1;
    localparam int unsigned ALU_NOT  = 0;

    typedef enum logic [2:0] {
        ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6
    } state_e;

    typedef enum logic [1:0] {
        CLS_BINARY, CLS_UNARY, CLS_MULDIV, CLS_ILLEGAL
    } opc_class_e;

    // Captured instruction; register fields sized for the largest build.
    typedef struct packed {
        logic [OPC_W-1:0]     opcode;
        logic [MAX_REG_W-1:0] ra;
        logic [MAX_REG_W-1:0] rb;
        logic [MAX_REG_W-1:0] rc;
    } instr_t;

    function automatic opc_class_e opc_class(input logic [OPC_W-1:0] opc);
        case (opc)
            OPC_AND, OPC_OR, OPC_ADD, OPC_SUB, OPC_SHR, OPC_SHRA,
            OPC_SHL, OPC_ROR, OPC_ROL: opc_class = CLS_BINARY;
            OPC_MUL, OPC_DIV:          opc_class = CLS_MULDIV;
            OPC_NEG, OPC_NOT:          opc_class = CLS_UNARY;
            default:                   opc_class = CLS_ILLEGAL;
        endcase
    endfunction

    function automatic logic [ALU_OP_W-1:0] alu_onehot(input logic [OPC_W-1:0] opc);
        alu_onehot = '0;
        case (opc)
            OPC_AND:  alu_onehot[ALU_AND]  = 1'b1;
            OPC_OR:   alu_onehot[ALU_OR]   = 1'b1;
            OPC_ADD:  alu_onehot[ALU_ADD]  = 1'b1;
            OPC_SUB:  alu_onehot[ALU_SUB]  = 1'b1;
            OPC_MUL:  alu_onehot[ALU_MUL]  = 1'b1;
            OPC_DIV:  alu_onehot[ALU_DIV]  = 1'b1;
            OPC_SHR:  alu_onehot[ALU_SHR]  = 1'b1;
            OPC_SHRA: alu_onehot[ALU_SHRA] = 1'b1;
            OPC_SHL:  alu_onehot[ALU_SHL]  = 1'b1;
            OPC_ROR:  alu_onehot[ALU_ROR]  = 1'b1;
            OPC_ROL:  alu_onehot[ALU_ROL]  = 1'b1;
            OPC_NEG:  alu_onehot[ALU_NEG]  = 1'b1;
            OPC_NOT:  alu_onehot[ALU_NOT]  = 1'b1;
            default:  alu_onehot = '0;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Sequencer <-> datapath interface: run/mem_wait/bus inputs to the sequencer
// and all datapath control strobes back. master = sequencer, slave = datapath.
interface alu_op_sequencer_if #(
    parameter int unsigned NREG   = 16,
    parameter int unsigned DATA_W = 32
);
    import alu_seq_pkg::*;

    logic                run;
    logic                mem_wait;
    logic [DATA_W-1:0]   bus;

    logic                pc_out, mar_in, inc_pc, pc_in;
    logic                read, mdr_in, mdr_out, ir_in;
    logic                y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in;
    logic [NREG-1:0]     reg_out;
    logic [NREG-1:0]     reg_in;
    logic [ALU_OP_W-1:0] alu_op;
    logic                busy, done, illegal;

    modport master (
        input  run, mem_wait, bus,
        output pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
               y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in,
               reg_out, reg_in, alu_op, busy, done, illegal
    );

    modport slave (
        output run, mem_wait, bus,
        input  pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
               y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in,
               reg_out, reg_in, alu_op, busy, done, illegal
    );
endinterface

// File: rtl/alu_op_sequencer_reg_onehot_dec.sv
// Register-select decoder: sel -> one-hot NREG-bit vector, all zero when en=0.
// Ports: en (enable), sel (REG_W register index), onehot (NREG enables).
module reg_onehot_dec #(
    parameter int unsigned NREG  = 16,
    parameter int unsigned REG_W = $clog2(NREG)
) (
    input  logic             en,
    input  logic [REG_W-1:0] sel,
    output logic [NREG-1:0]  onehot
);
    always_comb begin
        onehot = '0;
        if (en) onehot[sel] = 1'b1;
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// Control sequencer for a bus-based ALU datapath: fetches an instruction
// (T0..T2), then steps the register/ALU strobes (T3..T6) for its opcode.
// Ports: clk, reset (sync, active-high), sif (master side of
// alu_op_sequencer_if: run/mem_wait/bus in, control strobes out).
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned NREG   = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_op_sequencer_if.master   sif
);
    localparam int unsigned REG_W  = $clog2(NREG);
    localparam int unsigned RA_MSB = DATA_W - 1 - OPC_W;
    localparam int unsigned RB_MSB = RA_MSB - REG_W;
    localparam int unsigned RC_MSB = RB_MSB - REG_W;

    state_e     state_q, state_d;
    instr_t     instr_q;
    logic       illegal_q;
    opc_class_e cls_bus, cls_q;

    logic             ro_en, ri_en;
    logic [REG_W-1:0] ro_sel, ri_sel;

    logic [OPC_W-1:0] bus_opc;
    logic [REG_W-1:0] bus_ra, bus_rb, bus_rc;

    assign bus_opc = sif.bus[DATA_W-1 -: OPC_W];
    assign bus_ra  = sif.bus[RA_MSB -: REG_W];
    assign bus_rb  = sif.bus[RB_MSB -: REG_W];
    assign bus_rc  = sif.bus[RC_MSB -: REG_W];
    assign cls_bus = opc_class(bus_opc);
    assign cls_q   = opc_class(instr_q.opcode);

    // State register plus instruction capture and the post-decode illegal flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= (state_q == ST_T2) && (cls_bus == CLS_ILLEGAL);
            if (state_q == ST_T2) begin
                instr_q <= '{opcode: bus_opc,
                             ra:     MAX_REG_W'(bus_ra),
                             rb:     MAX_REG_W'(bus_rb),
                             rc:     MAX_REG_W'(bus_rc)};
            end
        end
    end

    // Next-state logic; T2 decodes straight from the bus since fields land at its end.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (sif.run) state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   if (!sif.mem_wait) state_d = ST_T2;
            ST_T2: begin
                case (cls_bus)
                    CLS_BINARY, CLS_MULDIV: state_d = ST_T3;
                    CLS_UNARY:              state_d = ST_T4;
                    default:                state_d = ST_IDLE;
                endcase
            end
            ST_T3:   state_d = ST_T4;
            ST_T4:   state_d = ST_T5;
            ST_T5: begin
                if (cls_q == CLS_MULDIV) state_d = ST_T6;
                else                     state_d = sif.run ? ST_T0 : ST_IDLE;
            end
            ST_T6:   state_d = sif.run ? ST_T0 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore output decode from state and captured fields.
    always_comb begin
        sif.pc_out    = 1'b0;
        sif.mar_in    = 1'b0;
        sif.inc_pc    = 1'b0;
        sif.pc_in     = 1'b0;
        sif.read      = 1'b0;
        sif.mdr_in    = 1'b0;
        sif.mdr_out   = 1'b0;
        sif.ir_in     = 1'b0;
        sif.y_in      = 1'b0;
        sif.z_in      = 1'b0;
        sif.zlow_out  = 1'b0;
        sif.zhigh_out = 1'b0;
        sif.lo_in     = 1'b0;
        sif.hi_in     = 1'b0;
        sif.alu_op    = '0;
        sif.done      = 1'b0;
        ro_en         = 1'b0;
        ro_sel        = '0;
        ri_en         = 1'b0;
        ri_sel        = '0;
        case (state_q)
            ST_T0: begin
                sif.pc_out = 1'b1;
                sif.mar_in = 1'b1;
                sif.inc_pc = 1'b1;
                sif.pc_in  = 1'b1;
            end
            ST_T1: begin
                sif.read   = 1'b1;
                sif.mdr_in = 1'b1;
            end
            ST_T2: begin
                sif.mdr_out = 1'b1;
                sif.ir_in   = 1'b1;
            end
            ST_T3: begin
                ro_en    = 1'b1;
                ro_sel   = REG_W'(instr_q.rb);
                sif.y_in = 1'b1;
            end
            ST_T4: begin
                sif.z_in   = 1'b1;
                sif.alu_op = alu_onehot(instr_q.opcode);
                ro_en      = 1'b1;
                ro_sel     = (cls_q == CLS_UNARY) ? REG_W'(instr_q.rb) : REG_W'(instr_q.rc);
            end
            ST_T5: begin
                sif.zlow_out = 1'b1;
                if (cls_q == CLS_MULDIV) begin
                    sif.lo_in = 1'b1;
                end else begin
                    ri_en    = 1'b1;
                    ri_sel   = REG_W'(instr_q.ra);
                    sif.done = 1'b1;
                end
            end
            ST_T6: begin
                sif.zhigh_out = 1'b1;
                sif.hi_in     = 1'b1;
                sif.done      = 1'b1;
            end
            default: ;
        endcase
    end

    assign sif.busy    = (state_q != ST_IDLE);
    assign sif.illegal = illegal_q;

    reg_onehot_dec #(.NREG(NREG), .REG_W(REG_W)) u_reg_out_dec (
        .en     (ro_en),
        .sel    (ro_sel),
        .onehot (sif.reg_out)
    );

    reg_onehot_dec #(.NREG(NREG), .REG_W(REG_W)) u_reg_in_dec (
        .en     (ri_en),
        .sel    (ri_sel),
        .onehot (sif.reg_in)
    );

endmodule
